// File: rtl/count_ctrl.sv
// count_ctrl: run controller for a two-digit BCD counter.
// Owns the count-step prescaler and sequences IDLE/RUN/PAUSE/DONE from
// single-cycle start/stop/pause command pulses (priority stop > pause > start).
// Optional build macro: AUTO_RELOAD_EN. When defined, the terminal step pulses
// done but the controller stays in RUN and wraps the count to 00 on the following step.
module count_ctrl #(
    parameter int unsigned DIV_N = 50000000,
    parameter int unsigned PRE_W = 26
) (
    input  logic       clkin,
    input  logic       clr,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [7:0] limit,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       done,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_N - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [3:0]       tens_q,  tens_d;
    logic [3:0]       ones_q,  ones_d;
    logic [3:0]       lim_t_q, lim_t_d;
    logic [3:0]       lim_o_q, lim_o_d;
    logic             tick_q,  tick_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic [3:0]       inc_tens, inc_ones;
    logic [3:0]       nxt_tens, nxt_ones;
    logic             hit_limit;

    // Latched limit digits are clamped so the count can always reach them.
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // BCD increment of the current count and the terminal-value compare.
    always_comb begin
        inc_tens = tens_q;
        inc_ones = ones_q + 4'd1;
        if (ones_q >= 4'd9) begin
            inc_ones = '0;
            inc_tens = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
        end
        nxt_tens = inc_tens;
        nxt_ones = inc_ones;
`ifdef AUTO_RELOAD_EN
        // Sitting on a non-zero limit: the next step wraps to 00. A limit of 00
        // wraps naturally at 99, so it needs no special case.
        if ({tens_q, ones_q} == {lim_t_q, lim_o_q} && {lim_t_q, lim_o_q} != 8'h00) begin
            nxt_tens = '0;
            nxt_ones = '0;
        end
`endif
        hit_limit = ({nxt_tens, nxt_ones} == {lim_t_q, lim_o_q});
    end

    // Next-state, prescaler, count and pulse generation.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        lim_t_d = lim_t_q;
        lim_o_d = lim_o_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pre_d   = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                    lim_t_d = clamp9(limit[7:4]);
                    lim_o_d = clamp9(limit[3:0]);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d  = '0;
                    tens_d = nxt_tens;
                    ones_d = nxt_ones;
                    tick_d = 1'b1;
                    if (hit_limit) begin
                        done_d = 1'b1;
`ifndef AUTO_RELOAD_EN
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            S_PAUSE: begin
                // Resume keeps the frozen prescaler so the step spacing is preserved.
                if (stop) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (start) begin
                    state_d = S_RUN;
                    pre_d   = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                    lim_t_d = clamp9(limit[7:4]);
                    lim_o_d = clamp9(limit[3:0]);
                end
            end
            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clkin) begin
        if (clr) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            lim_t_q <= '0;
            lim_o_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            lim_t_q <= lim_t_d;
            lim_o_q <= lim_o_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign tens  = tens_q;
    assign ones  = ones_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with a 4-cycle step (DIV_N=4).
module tb_count_ctrl;

    logic       clkin = 1'b0;
    logic       clr   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] limit = 8'h00;
    logic [3:0] tens, ones;
    logic       tick, done, busy;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

`ifdef AUTO_RELOAD_EN
    localparam logic [7:0] TERM_ST = 8'd1;
`else
    localparam logic [7:0] TERM_ST = 8'd3;
`endif

    count_ctrl #(.DIV_N(4), .PRE_W(3)) dut (
        .clkin(clkin), .clr(clr), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .tens(tens), .ones(ones), .tick(tick), .done(done),
        .busy(busy), .state(state)
    );

    always #5 clkin = ~clkin;

    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int k);
        int m;
        m = k % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    // Three quiet cycles then a step showing exp_cnt.
    task automatic step_chk(input logic [7:0] exp_cnt, input logic exp_done);
        repeat (3) begin
            cyc();
            chk("no_tick_between_steps", {7'd0, tick}, 8'd0);
        end
        cyc();
        chk("step_tick", {7'd0, tick}, 8'd1);
        chk("step_count", {tens, ones}, exp_cnt);
        chk("step_done", {7'd0, done}, {7'd0, exp_done});
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        clr = 1'b0;
        chk("rst_count", {tens, ones}, 8'h00);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_busy",  {7'd0, busy}, 8'd0);
        chk("rst_tick",  {7'd0, tick}, 8'd0);
        chk("rst_done",  {7'd0, done}, 8'd0);

        // stop/pause ignored in IDLE
        stop = 1'b1; pause = 1'b1; cyc(); stop = 1'b0; pause = 1'b0;
        chk("idle_ignore_state", {6'd0, state}, 8'd0);

        // Run to limit 12
        limit = 8'h12;
        pulse_start();
        limit = 8'h05;  // ignored until next latch
        chk("start_state", {6'd0, state}, 8'd1);
        chk("start_busy",  {7'd0, busy}, 8'd1);
        chk("start_count", {tens, ones}, 8'h00);
        for (int k = 1; k <= 12; k++) step_chk(bcd(k), k == 12);
        chk("lim12_state", {6'd0, state}, TERM_ST);
`ifndef AUTO_RELOAD_EN
        chk("lim12_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("done_hold_count", {tens, ones}, 8'h12);
            chk("done_hold_tick",  {7'd0, tick}, 8'd0);
            chk("done_hold_done",  {7'd0, done}, 8'd0);
        end
`endif
        pulse_stop();
        chk("stop_state", {6'd0, state}, 8'd0);

        // clr mid-run at 07, with a start held alongside
        limit = 8'h00;
        pulse_start();
        for (int k = 1; k <= 7; k++) step_chk(bcd(k), 1'b0);
        clr = 1'b1; start = 1'b1;
        cyc();
        chk("clr_count", {tens, ones}, 8'h00);
        chk("clr_state", {6'd0, state}, 8'd0);
        chk("clr_busy",  {7'd0, busy}, 8'd0);
        chk("clr_tick",  {7'd0, tick}, 8'd0);
        cyc(); cyc();
        clr = 1'b0; start = 1'b0;
        cyc();
        chk("clr_after_state", {6'd0, state}, 8'd0);

        // Full 100-step run with limit 00
        limit = 8'h00;
        pulse_start();
        for (int k = 1; k <= 100; k++) step_chk(bcd(k), k == 100);
        chk("full_state", {6'd0, state}, TERM_ST);
        pulse_stop();

        // Pause at 05 two cycles after its tick, resume keeps prescaler
        limit = 8'h20;
        pulse_start();
        for (int k = 1; k <= 5; k++) step_chk(bcd(k), 1'b0);
        cyc(); cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        chk("pause_state", {6'd0, state}, 8'd2);
        chk("pause_busy",  {7'd0, busy}, 8'd1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("pause_tick",  {7'd0, tick}, 8'd0);
            chk("pause_count", {tens, ones}, 8'h05);
        end
        pulse_start();
        chk("resume_state", {6'd0, state}, 8'd1);
        chk("resume_tick0", {7'd0, tick}, 8'd0);
        cyc();
        chk("resume_tick1", {7'd0, tick}, 8'd0);
        cyc();
        chk("resume_tick2",  {7'd0, tick}, 8'd1);
        chk("resume_count",  {tens, ones}, 8'h06);
        pulse_stop();
        chk("stop_hold_count", {tens, ones}, 8'h06);
        chk("stop_hold_state", {6'd0, state}, 8'd0);

        // stop+pause on a step edge at 03
        pulse_start();
        for (int k = 1; k <= 3; k++) step_chk(bcd(k), 1'b0);
        cyc(); cyc(); cyc();
        stop = 1'b1; pause = 1'b1; cyc(); stop = 1'b0; pause = 1'b0;
        chk("sp_state", {6'd0, state}, 8'd0);
        chk("sp_count", {tens, ones}, 8'h03);
        chk("sp_tick",  {7'd0, tick}, 8'd0);
        chk("sp_done",  {7'd0, done}, 8'd0);
        chk("sp_busy",  {7'd0, busy}, 8'd0);
        cyc();
        chk("sp_idle_count", {tens, ones}, 8'h03);
        pulse_start();
        chk("reload_count", {tens, ones}, 8'h00);
        step_chk(8'h01, 1'b0);
        pulse_stop();

        // Over-range ones digit latched as 9
        limit = 8'h0C;
        pulse_start();
        for (int k = 1; k <= 9; k++) step_chk(bcd(k), k == 9);
        chk("clamp_state", {6'd0, state}, TERM_ST);
        pulse_stop();

`ifdef AUTO_RELOAD_EN
        limit = 8'h03;
        pulse_start();
        step_chk(8'h01, 1'b0);
        step_chk(8'h02, 1'b0);
        step_chk(8'h03, 1'b1);
        chk("ar_busy",  {7'd0, busy}, 8'd1);
        chk("ar_state", {6'd0, state}, 8'd1);
        step_chk(8'h00, 1'b0);
        step_chk(8'h01, 1'b0);
        step_chk(8'h02, 1'b0);
        step_chk(8'h03, 1'b1);
        chk("ar_busy2", {7'd0, busy}, 8'd1);
        pulse_stop();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
